// File: rtl/core_pkg.sv
// core_pkg: shared core widths, reset/trap vectors and fetch sequencer state encoding
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_PC_DEFAULT  = 32'h0000_0100;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} pc_seq_state_t;
endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// pc_sequencer_pc_reg: program counter storage, loads the next-PC mux output every cycle
//   clk, rst : clock, asynchronous active-high reset (loads RESET_PC)
//   pc_d_i   : next PC
//   pc_q_o   : current PC
module pc_sequencer_pc_reg #(
    parameter int XLEN = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_d_i,
    output logic [XLEN-1:0] pc_q_o
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc_q_o <= RESET_PC;
        else pc_q_o <= pc_d_i;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer owning the PC; req/gnt/rvalid fetch, stall, redirect and trap
//   stall                           : decode cannot accept the held instruction
//   redirect_valid/redirect_target  : taken branch/jump and its target
//   trap_req                        : exception/interrupt, vectors to TRAP_PC
//   imem_req/imem_addr/imem_gnt     : fetch request channel
//   imem_rvalid/imem_rdata          : fetch response channel
//   instr_valid/instr/instr_pc      : instruction presented to decode
//   misalign_err                    : one-cycle pulse after a misaligned redirect
module pc_sequencer #(
    parameter int XLEN = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_PC = XLEN'(core_pkg::TRAP_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            misalign_err
);
    import core_pkg::*;

    pc_seq_state_t   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d, redir_pc;
    logic            kill_q, kill_d, mis_q, redir, mis;

    assign redir    = trap_req | redirect_valid;
    // A misaligned branch target is never loaded; it vectors like a trap instead.
    assign mis      = redirect_valid & ~trap_req & (redirect_target[1:0] != 2'b00);
    assign redir_pc = (trap_req | mis) ? TRAP_PC : redirect_target;

    always_comb begin
        state_d    = state_q;
        pc_d       = redir ? redir_pc : pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:
                if (imem_gnt) begin
                    state_d = WAIT;
                    // The old address was granted; its response must be discarded.
                    kill_d  = redir;
                end
            WAIT:
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || redir) state_d = REQ;
                    else begin
                        state_d    = HOLD;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                    end
                end else if (redir) kill_d = 1'b1;
            HOLD:
                if (redir) state_d = REQ;
                else if (!stall) begin
                    state_d = REQ;
                    pc_d    = pc_q + XLEN'(PC_INC);
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            mis_q      <= mis;
        end

    pc_sequencer_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .pc_d_i (pc_d),
        .pc_q_o (pc_q)
    );

    assign imem_req     = state_q == REQ;
    assign imem_addr    = pc_q;
    assign instr_valid  = state_q == HOLD;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = mis_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the program counter register and sequences instruction fetch for the core.
- Issues requests to instruction memory over a req/gnt/rvalid handshake and presents fetched instructions with their PC.
- Applies stall, branch/jump redirect and trap redirect with fixed priority.
- Sits between the PC register/adder datapath and decode.

Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on trap or misaligned redirect.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- stall  in  1  decode cannot accept the presented instruction
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  XLEN  new PC for redirect
- trap_req  in  1  exception/interrupt redirect request
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (current PC)
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  XLEN  fetched instruction
- instr_valid  out  1  instr/instr_pc valid for decode
- instr  out  XLEN  held instruction
- instr_pc  out  XLEN  PC of held instruction
- misalign_err  out  1  one-cycle pulse: redirect target bits[1:0] != 0

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: pc = RESET_PC, state = IDLE, kill = 0; outputs imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0, misalign_err = 0. Reset asserted mid-fetch aborts immediately; any later imem_rvalid is ignored until a new request is granted.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: one cycle after reset release, then -> REQ.
  - REQ: imem_req = 1, imem_addr = pc. gnt=1 -> WAIT; otherwise stay in REQ.
  - WAIT: on rvalid: if kill = 0, latch instr = imem_rdata and instr_pc = pc, then -> HOLD; if kill = 1, clear kill, drop the data, -> REQ.
  - HOLD: instr_valid = 1. When stall = 0 the instruction is consumed: pc <= pc + 4 (wraps modulo 2^XLEN), -> REQ, instr_valid = 0 next cycle. When stall = 1, hold everything unchanged.
- Redirect priority: trap_req > redirect_valid > stall > sequential.
  - Trap: pc <= TRAP_PC.
  - Redirect: pc <= redirect_target.
- Redirect/trap effect per state:
  - REQ with gnt=0: pc updates; next-cycle imem_addr shows the new PC. The address may change before grant; this is part of the protocol.
  - REQ with gnt=1 in the same cycle: the old address is granted; pc updates, kill <= 1, -> WAIT.
  - WAIT: pc updates, kill <= 1; stay in WAIT until rvalid. If rvalid arrives in the same cycle as the redirect, drop it and -> REQ.
  - HOLD: drop the held instruction (instr_valid 0 next cycle), pc updates, -> REQ. This applies even with stall = 1.
  - IDLE: pc updates, -> REQ.
- Misaligned redirect (redirect_valid, no trap, target[1:0] != 0):
  - Target is not loaded; pc <= TRAP_PC.
  - misalign_err = 1 for exactly one cycle (registered, the cycle after).
  - Handled like a trap in every other respect.
- trap_req and redirect_valid together: trap wins, no misalign_err.
- Latency: with gnt and rvalid each one cycle after entering their state, instr_valid rises 3 cycles after entering REQ. Best-case throughput is 1 instruction per 3 cycles.
- imem_req is deasserted in IDLE, WAIT and HOLD; at most one outstanding request at a time.

Decomposition:
- Shared package core_pkg:
  - state enum pc_seq_state_t {IDLE, REQ, WAIT, HOLD}
  - XLEN
  - constants RESET_PC_DEFAULT, TRAP_PC_DEFAULT, PC_INC = 4
- Sub-module: the existing pc register, instantiated for PC storage with its new-PC input driven by the sequencer's next-PC mux. All control and priority logic stays in pc_sequencer.

Test Plan:
- Reset then run, memory with gnt/rvalid 1 cycle after request, stall = 0 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_pc matches; instr_valid pulses every 3 cycles.
- Stall = 1 for 5 cycles in HOLD at pc 0x8 -> instr and instr_pc stay at 0x8, no imem_req; fetch of 0xC starts one cycle after stall drops.
- Redirect to 0x40 while in WAIT for 0x4 -> rvalid data for 0x4 is dropped (instr_valid stays 0); next imem_addr = 0x40.
- Redirect to 0x42 -> misalign_err pulses once; next imem_addr = TRAP_PC (0x100).
- trap_req and redirect_valid (0x80) in the same cycle while in HOLD -> next imem_addr = 0x100, no misalign_err.
- rst asserted while in WAIT -> outputs cleared asynchronously; a stale rvalid after release is ignored; first imem_addr = 0x0.
